vga_scan_controller: RTL and testbench

Raster timing generator and RGB output stage for the VGA path. It drives `pixelX`/`pixelY` to the background and object drawers and receives their 8-bit 3-3-2 colour one or more cycles later. It then emits delay-aligned sync, blank and 8-8-8 colour to the VGA DAC pins. It is the scan-side counterpart of the drawers: it produces the coordinates they consume and consumes the colour they produce.

---
 rtl/vga_scan_controller.sv | 160 ++++++++++++++++
 tb/tb_vga_scan_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_controller.sv
// VGA raster timing generator with a delay-matched sync/blank/colour stage.
// Counters feed the drawers; the output register realigns decode with RGBIn.
module vga_scan_controller #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [7:0]  frameCount,
    output logic        hSync,
    output logic        vSync,
    output logic        blankN,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] X_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] Y_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] X_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] Y_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic        run_q;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [7:0]  fc_q, fc_d;
    logic        sof_q, sof_d;

    // First edge after reset re-presents (0,0) and pulses start-of-frame.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        fc_d = fc_q;
        if (!run_q) begin
            x_d = '0;
            y_d = '0;
        end else if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
                y_d  = '0;
                fc_d = fc_q + 8'd1;
            end else begin
                y_d = y_q + 11'd1;
            end
        end else begin
            x_d = x_q + 11'd1;
        end
        sof_d = (x_d == 11'd0) && (y_d == 11'd0);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            run_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            fc_q  <= '0;
            sof_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            x_q   <= x_d;
            y_q   <= y_d;
            fc_q  <= fc_d;
            sof_q <= sof_d;
        end
    end

    logic act_raw, hs_raw, vs_raw;

    always_comb begin
        act_raw = run_q && (x_q < X_ACT) && (y_q < Y_ACT);
        hs_raw  = !(run_q && (x_q >= HS_BEG) && (x_q <= HS_END));
        vs_raw  = !(run_q && (y_q >= VS_BEG) && (y_q <= VS_END));
    end

    logic [PIPE_DELAY-1:0] act_p_q, hs_p_q, vs_p_q;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            act_p_q <= '0;
            hs_p_q  <= '1;
            vs_p_q  <= '1;
        end else begin
            act_p_q[0] <= act_raw;
            hs_p_q[0]  <= hs_raw;
            vs_p_q[0]  <= vs_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                act_p_q[i] <= act_p_q[i-1];
                hs_p_q[i]  <= hs_p_q[i-1];
                vs_p_q[i]  <= vs_p_q[i-1];
            end
        end
    end

    logic       act_dly;
    logic [7:0] red_d, green_d, blue_d;

    // 3-3-2 to 8-8-8 by bit replication so full scale maps to 8'hFF.
    always_comb begin
        act_dly = act_p_q[PIPE_DELAY-1];
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (act_dly) begin
            red_d   = {RGBIn[7:5], RGBIn[7:5], RGBIn[7:6]};
            green_d = {RGBIn[4:2], RGBIn[4:2], RGBIn[4:3]};
            blue_d  = {4{RGBIn[1:0]}};
        end
    end

    logic       hs_q, vs_q, bn_q;
    logic [7:0] red_q, green_q, blue_q;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            bn_q    <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            hs_q    <= hs_p_q[PIPE_DELAY-1];
            vs_q    <= vs_p_q[PIPE_DELAY-1];
            bn_q    <= act_dly;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign pixelX       = x_q;
    assign pixelY       = y_q;
    assign startOfFrame = sof_q;
    assign frameCount   = fc_q;
    assign hSync        = hs_q;
    assign vSync        = vs_q;
    assign blankN       = bn_q;
    assign red          = red_q;
    assign green        = green_q;
    assign blue         = blue_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: full-size timing instance plus a small
// timing instance with a 3-stage drawer, both checked against a raster model.
module tb_vga_scan_controller;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        int pd;
    } tim_t;

    localparam int BHA = 16, BHF = 4, BHS = 6, BHB = 4;
    localparam int BVA = 8,  BVF = 2, BVS = 2, BVB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA_n, rstB_n;
    logic [7:0]  rgbA, rgbB;
    logic [10:0] pxA, pyA, pxB, pyB;
    logic        sofA, sofB, hsA, hsB, vsA, vsB, bnA, bnB;
    logic [7:0]  fcA, fcB, rA, gA, bA, rB, gB, bB;

    vga_scan_controller #(.PIPE_DELAY(1)) dut_a (
        .clk(clk), .resetN(rstA_n), .RGBIn(rgbA),
        .pixelX(pxA), .pixelY(pyA), .startOfFrame(sofA),
        .frameCount(fcA), .hSync(hsA), .vSync(vsA), .blankN(bnA),
        .red(rA), .green(gA), .blue(bA)
    );

    vga_scan_controller #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
        .PIPE_DELAY(3)
    ) dut_b (
        .clk(clk), .resetN(rstB_n), .RGBIn(rgbB),
        .pixelX(pxB), .pixelY(pyB), .startOfFrame(sofB),
        .frameCount(fcB), .hSync(hsB), .vSync(vsB), .blankN(bnB),
        .red(rB), .green(gB), .blue(bB)
    );

    int errors = 0;
    int checks = 0;
    tim_t ta, tb;
    int nA = -1, nB = -1;
    int ph = 0;
    logic [7:0] drawq[$];
    int hsFallA = -1, hsLowA = 0, bnHiA = 0, yAt800 = -1;
    logic hsPrevA = 1'b1;
    int sofB_q[$];
    int vsLowB = 0, fcAt450 = -1, vsEarly = 0;
    logic bn3 = 1'bx, bn4 = 1'bx;
    logic [7:0] b5 = 8'hxx, rgb4 = 8'hxx;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raster model: edge n after release shows counters for pixel n and
    // outputs for pixel n-(pd+1), in plain frame/line arithmetic.
    task automatic model_check(
        input string nm, input tim_t t, input int n,
        input logic [7:0] rgb, input bit use_x,
        input logic [10:0] px, input logic [10:0] py,
        input logic sof, input logic [7:0] fc,
        input logic hs, input logic vs, input logic bn,
        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int ht, vt, ft, idx, q, qx, qy;
        int ex, ey, esof, efc, ehs, evs, ebn;
        logic [7:0] c, er, eg, eb;
        ht = t.ha + t.hf + t.hs + t.hb;
        vt = t.va + t.vf + t.vs + t.vb;
        ft = ht * vt;
        ex = 0; ey = 0; esof = 0; efc = 0;
        ehs = 1; evs = 1; ebn = 0;
        er = 0; eg = 0; eb = 0;
        if (n >= 0) begin
            idx  = n % ft;
            ex   = idx % ht;
            ey   = idx / ht;
            esof = (idx == 0) ? 1 : 0;
            efc  = (n / ft) % 256;
            q    = n - (t.pd + 1);
            if (q >= 0) begin
                qx  = (q % ft) % ht;
                qy  = (q % ft) / ht;
                ebn = (qx < t.ha && qy < t.va) ? 1 : 0;
                ehs = (qx >= t.ha + t.hf && qx < t.ha + t.hf + t.hs) ? 0 : 1;
                evs = (qy >= t.va + t.vf && qy < t.va + t.vf + t.vs) ? 0 : 1;
                c = use_x ? 8'(qx) : rgb;
                if (ebn == 1) begin
                    er = {c[7:5], c[7:5], c[7:6]};
                    eg = {c[4:2], c[4:2], c[4:3]};
                    eb = {c[1:0], c[1:0], c[1:0], c[1:0]};
                end
            end
        end
        chk({nm, ".pixelX"}, 32'(px), 32'(ex));
        chk({nm, ".pixelY"}, 32'(py), 32'(ey));
        chk({nm, ".sof"}, 32'(sof), 32'(esof));
        chk({nm, ".frameCount"}, 32'(fc), 32'(efc));
        chk({nm, ".hSync"}, 32'(hs), 32'(ehs));
        chk({nm, ".vSync"}, 32'(vs), 32'(evs));
        chk({nm, ".blankN"}, 32'(bn), 32'(ebn));
        chk({nm, ".red"}, 32'(r), 32'(er));
        chk({nm, ".green"}, 32'(g), 32'(eg));
        chk({nm, ".blue"}, 32'(b), 32'(eb));
    endtask

    task automatic step();
        logic [7:0] prevA;
        logic ra, rb;
        prevA = rgbA;
        ra = rstA_n;
        rb = rstB_n;
        @(posedge clk);
        nA = ra ? nA + 1 : -1;
        nB = rb ? nB + 1 : -1;
        #1;
        drawq.push_back(pxB[7:0]);
        if (drawq.size() > 3) rgbB = drawq.pop_front();
        model_check("A", ta, nA, prevA, 1'b0, pxA, pyA, sofA, fcA,
                    hsA, vsA, bnA, rA, gA, bA);
        model_check("B", tb, nB, 8'h00, 1'b1, pxB, pyB, sofB, fcB,
                    hsB, vsB, bnB, rB, gB, bB);
        if (nA >= 2 && nA <= 801) begin
            if (!hsA) hsLowA++;
            if (bnA) bnHiA++;
            if (!hsA && hsPrevA && hsFallA < 0) hsFallA = nA;
        end
        hsPrevA = hsA;
        if (nA == 800) yAt800 = int'(pyA);
        if (ph < 5 && nB >= 0) begin
            if (sofB) sofB_q.push_back(nB);
            if (nB < 450 && !vsB) vsLowB++;
            if (nB == 450) fcAt450 = int'(fcB);
            if (nB == 3) bn3 = bnB;
            if (nB == 4) begin
                bn4 = bnB;
                rgb4 = rB | gB | bB;
            end
            if (nB == 5) b5 = bB;
        end
        if (ph == 5 && nB >= 0 && nB < BVA * 30 + 2 * 30 + 4) begin
            if (!vsB) vsEarly++;
        end
    endtask

    initial begin
        int k;
        ta = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, pd:1};
        tb = '{ha:BHA, hf:BHF, hs:BHS, hb:BHB,
               va:BVA, vf:BVF, vs:BVS, vb:BVB, pd:3};
        rstA_n = 1'b0;
        rstB_n = 1'b0;
        rgbA = 8'h00;
        rgbB = 8'h00;

        // Reset, then release: first edge presents (0,0) with a sof pulse.
        ph = 1;
        repeat (3) step();
        rstA_n = 1'b1;
        rstB_n = 1'b1;
        rgbA = 8'($urandom);
        step();
        chk("first_sof", 32'(sofA), 32'd1);
        chk("first_px", 32'(pxA), 32'd0);
        rgbA = 8'($urandom);
        step();
        chk("second_sof", 32'(sofA), 32'd0);

        // Two full lines with random colour.
        ph = 2;
        while (nA < 1600) begin
            rgbA = 8'($urandom);
            step();
        end
        chk("hs_fall_edge", 32'(hsFallA), 32'd658);
        chk("hs_low_len", 32'(hsLowA), 32'd96);
        chk("blank_hi_len", 32'(bnHiA), 32'd640);
        chk("y_step_0_1", 32'(yAt800), 32'd1);

        // Constant colours in active video and in blanking.
        ph = 3;
        rgbA = 8'hE0;
        repeat (10) step();
        chk("E0.red", 32'(rA), 32'hFF);
        chk("E0.green", 32'(gA), 32'h00);
        chk("E0.blue", 32'(bA), 32'h00);
        rgbA = 8'h1F;
        repeat (10) step();
        chk("1F.red", 32'(rA), 32'h00);
        chk("1F.green", 32'(gA), 32'hFF);
        chk("1F.blue", 32'(bA), 32'hFF);
        k = 0;
        while (nA % 800 != 702 && k < 1000) begin
            step();
            k++;
        end
        chk("blank_wait", 32'(k < 1000), 32'd1);
        chk("blank.bn", 32'(bnA), 32'd0);
        chk("blank.rgb", 32'({rA, gA, bA}), 32'd0);

        // Keep both running to cover several small frames of instance B.
        ph = 4;
        while (nB < 1000) begin
            rgbA = 8'($urandom);
            step();
        end
        chk("B.sof_count_ge2", 32'(sofB_q.size() >= 2), 32'd1);
        if (sofB_q.size() >= 2)
            chk("B.sof_period", 32'(sofB_q[1] - sofB_q[0]), 32'd450);
        chk("B.vs_low_len", 32'(vsLowB), 32'd60);
        chk("B.fc_after_frame", 32'(fcAt450), 32'd1);
        chk("B.blank_edge3", 32'(bn3), 32'd0);
        chk("B.blank_edge4", 32'(bn4), 32'd1);
        chk("B.rgb_edge4", 32'(rgb4), 32'd0);
        chk("B.blue_edge5", 32'(b5), 32'h55);

        // One-cycle reset while both syncs are low, then a clean restart.
        k = 0;
        while (!(vsB === 1'b0 && hsB === 1'b0) && k < 2000) begin
            rgbA = 8'($urandom);
            step();
            k++;
        end
        chk("B.sync_wait", 32'(k < 2000), 32'd1);
        ph = 5;
        rstB_n = 1'b0;
        step();
        chk("B.rst.hSync", 32'(hsB), 32'd1);
        chk("B.rst.vSync", 32'(vsB), 32'd1);
        chk("B.rst.px", 32'(pxB), 32'd0);
        chk("B.rst.py", 32'(pyB), 32'd0);
        rstB_n = 1'b1;
        repeat (900) begin
            rgbA = 8'($urandom);
            step();
        end
        chk("B.no_trunc_vs", 32'(vsEarly), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
